i2c_slave_ctrl: RTL and testbench

Bit-level sequencer for the I2C slave datapath. It samples pre-synchronised SCL/SDA in the `pclk` domain and detects START, STOP and SCL edges. From these it drives the shift-register block's load, shift, ACK-select and output-enable controls through the address, write-data, read-data and acknowledge phases. It sits between the pad/synchroniser logic and the shift-register block, and reports byte-level events to the register file.

---
 rtl/i2c_slave_ctrl_if.sv | 31 +++
 rtl/i2c_slave_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_i2c_slave_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_ctrl_if.sv
// rtl/i2c_slave_ctrl_if.sv - bus bundle between pads, shift block, register file and the I2C slave sequencer
interface i2c_slave_ctrl_if;
  // Synchronised bus lines and shift-block status
  logic scl_in;
  logic sda_in;
  logic comp_match;
  logic read;
  // Shift-block controls
  logic shift_en;
  logic shift_load_en;
  logic ack_cycle;
  logic dack_cycle;
  logic sda_oe;
  // Byte-level events and status
  logic rx_valid;
  logic tx_req;
  logic busy;
  logic addressed;

  modport slave (
    input  scl_in, sda_in, comp_match, read,
    output shift_en, shift_load_en, ack_cycle, dack_cycle, sda_oe,
    output rx_valid, tx_req, busy, addressed
  );

  modport master (
    output scl_in, sda_in, comp_match, read,
    input  shift_en, shift_load_en, ack_cycle, dack_cycle, sda_oe,
    input  rx_valid, tx_req, busy, addressed
  );
endinterface

// File: rtl/i2c_slave_ctrl.sv
// rtl/i2c_slave_ctrl.sv - bit-level I2C slave sequencer driving the shift-register block
module i2c_slave_ctrl (
  input logic             pclk_i,
  input logic             presetn_i,
  i2c_slave_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_RX_DATA,
    S_RX_ACK,
    S_TX_DATA,
    S_TX_ACK,
    S_WAIT_STOP
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic       mack_q, mack_d;
  logic       addressed_q, addressed_d;
  logic       scl_q, sda_q;

  logic       rise, fall, start_c, stop_c;
  logic       cnt_full, cnt_mid;
  logic [3:0] cnt_inc;

  logic       shift_en_c, shift_load_en_c, ack_cycle_c, dack_cycle_c;
  logic       sda_oe_c, rx_valid_c, tx_req_c;

  // Edge flags compare the live line against last cycle's sample. START/STOP
  // need SCL high on both samples, so they can never coincide with an SCL edge.
  assign rise    = bus.scl_in & ~scl_q;
  assign fall    = ~bus.scl_in & scl_q;
  assign start_c = bus.scl_in & scl_q & sda_q & ~bus.sda_in;
  assign stop_c  = bus.scl_in & scl_q & ~sda_q & bus.sda_in;

  assign cnt_full = (bit_cnt_q == 4'd8);
  assign cnt_mid  = (bit_cnt_q >= 4'd1) && (bit_cnt_q <= 4'd7);
  // Saturating increment: extra rises once the byte is complete are dropped
  assign cnt_inc  = cnt_full ? bit_cnt_q : bit_cnt_q + 4'd1;

  // Next-state: bus conditions first, then per-phase SCL edge handling
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    mack_d      = mack_q;
    addressed_d = addressed_q;
    if (stop_c) begin
      state_d     = S_IDLE;
      addressed_d = 1'b0;
    end else if (start_c) begin
      state_d     = S_ADDR;
      bit_cnt_d   = 4'd0;
      addressed_d = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (rise) begin
            bit_cnt_d = cnt_inc;
          end else if (fall && cnt_full) begin
            if (bus.comp_match) begin
              state_d     = S_ADDR_ACK;
              addressed_d = 1'b1;
            end else begin
              state_d = S_WAIT_STOP;
            end
          end
        end
        S_ADDR_ACK: begin
          if (fall) begin
            bit_cnt_d = 4'd0;
            state_d   = bus.read ? S_TX_DATA : S_RX_DATA;
          end
        end
        S_RX_DATA: begin
          if (rise) begin
            bit_cnt_d = cnt_inc;
          end else if (fall && cnt_full) begin
            state_d = S_RX_ACK;
          end
        end
        S_RX_ACK: begin
          if (fall) begin
            bit_cnt_d = 4'd0;
            state_d   = S_RX_DATA;
          end
        end
        S_TX_DATA: begin
          if (rise) begin
            bit_cnt_d = cnt_inc;
          end else if (fall && cnt_full) begin
            state_d = S_TX_ACK;
          end
        end
        S_TX_ACK: begin
          if (rise) begin
            mack_d = ~bus.sda_in;
          end else if (fall) begin
            if (mack_q) begin
              bit_cnt_d = 4'd0;
              state_d   = S_TX_DATA;
            end else begin
              state_d = S_WAIT_STOP;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Shift-block controls and event pulses, decoded from state and this cycle's edges
  always_comb begin
    shift_en_c      = 1'b0;
    shift_load_en_c = 1'b0;
    ack_cycle_c     = 1'b0;
    dack_cycle_c    = 1'b0;
    sda_oe_c        = 1'b0;
    rx_valid_c      = 1'b0;
    tx_req_c        = 1'b0;
    case (state_q)
      S_ADDR: begin
        shift_en_c = rise & ~cnt_full;
      end
      S_ADDR_ACK: begin
        ack_cycle_c     = 1'b1;
        sda_oe_c        = 1'b1;
        shift_load_en_c = fall & bus.read;
      end
      S_RX_DATA: begin
        shift_en_c = rise & ~cnt_full;
        rx_valid_c = fall & cnt_full;
      end
      S_RX_ACK: begin
        dack_cycle_c = 1'b1;
        sda_oe_c     = 1'b1;
      end
      S_TX_DATA: begin
        ack_cycle_c  = 1'b1;
        dack_cycle_c = 1'b1;
        sda_oe_c     = 1'b1;
        // The MSB is already on the pad after the load, so only 7 shifts per byte
        shift_en_c   = fall & cnt_mid;
      end
      S_TX_ACK: begin
        tx_req_c        = rise & ~bus.sda_in;
        shift_load_en_c = fall & mack_q;
      end
      default: begin
      end
    endcase
  end

  // State, counter, flags and line samples; reset parks the lines high so no edge is seen
  always_ff @(posedge pclk_i) begin
    if (!presetn_i) begin
      state_q     <= S_IDLE;
      bit_cnt_q   <= 4'd0;
      mack_q      <= 1'b0;
      addressed_q <= 1'b0;
      scl_q       <= 1'b1;
      sda_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      mack_q      <= mack_d;
      addressed_q <= addressed_d;
      scl_q       <= bus.scl_in;
      sda_q       <= bus.sda_in;
    end
  end

  assign bus.shift_en      = shift_en_c;
  assign bus.shift_load_en = shift_load_en_c;
  assign bus.ack_cycle     = ack_cycle_c;
  assign bus.dack_cycle    = dack_cycle_c;
  assign bus.sda_oe        = sda_oe_c;
  assign bus.rx_valid      = rx_valid_c;
  assign bus.tx_req        = tx_req_c;
  assign bus.busy          = (state_q != S_IDLE);
  assign bus.addressed     = addressed_q;

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// tb/tb_i2c_slave_ctrl.sv - directed scoreboard bench for the I2C slave sequencer
module tb_i2c_slave_ctrl;

  localparam int Q = 5;

  logic pclk = 1'b0;
  logic presetn = 1'b0;
  logic scl = 1'b1;
  logic sda_m = 1'b1;

  i2c_slave_ctrl_if bus_if ();

  i2c_slave_ctrl dut (
    .pclk_i   (pclk),
    .presetn_i(presetn),
    .bus      (bus_if)
  );

  always #5 pclk = ~pclk;

  // Shift-block model: 8-bit register, address compare against 0x52
  logic [7:0] dr = 8'h00;
  logic [7:0] tx_tbl [16];
  int         tx_idx = 0;
  logic [7:0] tx_data;
  logic       sda_out, sda_bus;

  assign tx_data = tx_tbl[tx_idx[3:0]];
  assign sda_out = ({bus_if.ack_cycle, bus_if.dack_cycle} == 2'b10) ? ~bus_if.comp_match :
                   ({bus_if.ack_cycle, bus_if.dack_cycle} == 2'b01) ? 1'b0 :
                   ({bus_if.ack_cycle, bus_if.dack_cycle} == 2'b11) ? dr[7] : 1'b1;
  assign sda_bus = sda_m & (bus_if.sda_oe ? sda_out : 1'b1);

  assign bus_if.scl_in     = scl;
  assign bus_if.sda_in     = sda_bus;
  assign bus_if.comp_match = (dr[7:1] == 7'h52);
  assign bus_if.read       = dr[0];

  always @(posedge pclk) begin
    if (bus_if.shift_load_en) dr <= tx_data;
    else if (bus_if.shift_en) dr <= {dr[6:0], sda_bus};
  end

  // Monitor: log received bytes, tx_req pulses and any SDA drive
  logic [7:0] rx_log [64];
  int rx_cnt = 0;
  int oe_cnt = 0;
  always @(negedge pclk) begin
    if (bus_if.rx_valid) begin
      rx_log[rx_cnt[5:0]] <= dr;
      rx_cnt <= rx_cnt + 1;
    end
    if (bus_if.tx_req) tx_idx <= tx_idx + 1;
    if (bus_if.sda_oe) oe_cnt <= oe_cnt + 1;
  end

  int checks = 0;
  int errors = 0;
  int rx_rd = 0;
  logic [7:0] exp_rx [$];
  logic [7:0] exp_tx [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] outs_now();
    return {bus_if.shift_en, bus_if.shift_load_en, bus_if.ack_cycle, bus_if.dack_cycle,
            bus_if.sda_oe, bus_if.rx_valid, bus_if.tx_req, bus_if.busy, bus_if.addressed};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic start_cond();
    sda_m = 1'b1; tick(Q);
    scl = 1'b1;   tick(Q);
    sda_m = 1'b0; tick(Q);
    scl = 1'b0;   tick(Q);
  endtask

  task automatic stop_cond(input string tag);
    sda_m = 1'b0; tick(Q);
    scl = 1'b1;   tick(Q);
    sda_m = 1'b1; tick(1);
    chk({tag, "_stop_busy"}, bus_if.busy, 1'b0);
    chk({tag, "_stop_oe"}, bus_if.sda_oe, 1'b0);
    chk({tag, "_stop_addressed"}, bus_if.addressed, 1'b0);
    tick(Q);
  endtask

  task automatic clk_bit(input logic b, output logic s);
    sda_m = b; tick(Q);
    scl = 1'b1; tick(Q);
    s = sda_bus;
    scl = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic s;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, s);
      d = {d[6:0], s};
    end
    clk_bit(nack, s);
  endtask

  task automatic drain_rx(input string tag);
    while (rx_rd < rx_cnt) begin
      if (exp_rx.size() == 0) chk({tag, "_rx_extra"}, rx_log[rx_rd[5:0]], 32'hFFFF_FFFF);
      else chk({tag, "_rx_byte"}, rx_log[rx_rd[5:0]], exp_rx.pop_front());
      rx_rd++;
    end
    chk({tag, "_rx_missing"}, exp_rx.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       a, s;
    logic [7:0] d, e;
    int         base, oe0, t0;
    for (int i = 0; i < 16; i++) tx_tbl[i] = 8'h00;

    // Reset state
    tick(3);
    chk("reset_outs", outs_now(), 9'd0);
    presetn = 1'b1;
    tick(2);
    chk("idle_outs", outs_now(), 9'd0);

    // Write 0x52: 0xA5, 0x3C
    base = rx_cnt;
    exp_rx.push_back(8'hA5);
    exp_rx.push_back(8'h3C);
    start_cond();
    chk("w_busy", bus_if.busy, 1'b1);
    write_byte(8'hA4, a); chk("w_addr_ack", a, 1'b0);
    chk("w_addressed", bus_if.addressed, 1'b1);
    write_byte(8'hA5, a); chk("w_d0_ack", a, 1'b0);
    write_byte(8'h3C, a); chk("w_d1_ack", a, 1'b0);
    stop_cond("w");
    drain_rx("w");
    chk("w_rx_count", rx_cnt - base, 2);

    // Address 0x11: never driven, no data accepted
    base = rx_cnt;
    oe0 = oe_cnt;
    start_cond();
    write_byte(8'h22, a); chk("nm_addr_nack", a, 1'b1);
    write_byte(8'h55, a); chk("nm_d0_nack", a, 1'b1);
    write_byte(8'hFF, a); chk("nm_d1_nack", a, 1'b1);
    chk("nm_wait_busy", bus_if.busy, 1'b1);
    chk("nm_addressed", bus_if.addressed, 1'b0);
    stop_cond("nm");
    chk("nm_oe_never", oe_cnt - oe0, 0);
    chk("nm_no_rx", rx_cnt - base, 0);

    // Read 0x52: 0xC3 (ACK), 0x0F (NACK)
    t0 = tx_idx;
    tx_tbl[t0[3:0]] = 8'hC3;
    tx_tbl[t0[3:0] + 4'd1] = 8'h0F;
    exp_tx.push_back(8'hC3);
    exp_tx.push_back(8'h0F);
    start_cond();
    write_byte(8'hA5, a); chk("r_addr_ack", a, 1'b0);
    read_byte(1'b0, d); chk("r_byte0", d, exp_tx.pop_front());
    read_byte(1'b1, d); chk("r_byte1", d, exp_tx.pop_front());
    chk("r_tx_req_count", tx_idx - t0, 1);
    chk("r_wait_busy", bus_if.busy, 1'b1);
    chk("r_wait_oe", bus_if.sda_oe, 1'b0);
    stop_cond("r");

    // Repeated START after 4 write data bits, then read
    base = rx_cnt;
    start_cond();
    write_byte(8'hA4, a); chk("rs_addr_ack", a, 1'b0);
    clk_bit(1'b1, s); clk_bit(1'b0, s); clk_bit(1'b1, s); clk_bit(1'b1, s);
    t0 = tx_idx;
    tx_tbl[t0[3:0]] = 8'h96;
    exp_tx.push_back(8'h96);
    start_cond();
    chk("rs_addressed_clr", bus_if.addressed, 1'b0);
    write_byte(8'hA5, a); chk("rs_raddr_ack", a, 1'b0);
    read_byte(1'b1, d); chk("rs_byte", d, exp_tx.pop_front());
    stop_cond("rs");
    chk("rs_no_rx", rx_cnt - base, 0);

    // Reset pulse during the address ACK low phase
    start_cond();
    e = 8'hA4;
    for (int i = 7; i >= 0; i--) clk_bit(e[i], s);
    chk("rst_ack_oe", bus_if.sda_oe, 1'b1);
    presetn = 1'b0;
    tick(1);
    presetn = 1'b1;
    chk("rst_outs", outs_now(), 9'd0);
    tick(Q);
    chk("rst_still_idle", outs_now(), 9'd0);
    start_cond();
    write_byte(8'hA4, a); chk("rst_readdr_ack", a, 1'b0);
    stop_cond("rst");

    // STOP injected in TX_DATA after 3 bits
    t0 = tx_idx;
    tx_tbl[t0[3:0]] = 8'h5A;
    e = 8'h5A;
    start_cond();
    write_byte(8'hA5, a); chk("st_addr_ack", a, 1'b0);
    for (int i = 0; i < 3; i++) begin
      clk_bit(1'b1, s);
      chk("st_tx_bit", s, e[7 - i]);
    end
    chk("st_tx_oe", bus_if.sda_oe, 1'b1);
    stop_cond("st");

    drain_rx("end");
    chk("tx_queue_empty", exp_tx.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
